// File: rtl/hit_arbiter.sv
// -----------------------------------------------------------------------------
// hit_arbiter
//
// Multi-channel hit front-end for the muon DAQ. Each raw discriminator input
// is synchronised through two flops, rising edges are detected on a third
// history flop, and every accepted edge is latched as a pending hit together
// with the free-running timestamp of the cycle in which the edge was seen.
// Pending hits are drained round-robin onto one valid/ready event port.
// Hits arriving on a channel that still holds an undelivered hit are lost to
// pile-up and counted in a saturating drop counter.
//
// Handshake: o_valid/o_channel/o_timestamp are registered. Once o_valid is
// high, o_channel and o_timestamp stay stable until a cycle with
// o_valid & i_ready; that edge completes the transfer and o_valid drops for
// at least one cycle, so at most one event is transferred every two clocks.
// The only exit from an offer without handshake is reset.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   i_hits       raw asynchronous channel inputs
//   i_enable     1 = accept new hits
//   i_ch_mask    per-channel enable for new hits
//   i_clr_ovf    synchronous clear of o_ovf_cnt (wins over same-cycle drops)
//   i_ready      downstream ready
//   o_valid      event valid
//   o_channel    channel of the offered event
//   o_timestamp  timestamp of the offered event
//   o_ovf_cnt    saturating dropped-hit count
//   o_busy       any channel pending or an event on offer
// -----------------------------------------------------------------------------
module hit_arbiter #(
    parameter int N_CH  = 8,
    parameter int TS_W  = 32,
    parameter int OVF_W = 16,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   i_hits,
    input  logic              i_enable,
    input  logic [N_CH-1:0]   i_ch_mask,
    input  logic              i_clr_ovf,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [CH_W-1:0]   o_channel,
    output logic [TS_W-1:0]   o_timestamp,
    output logic [OVF_W-1:0]  o_ovf_cnt,
    output logic              o_busy
);

    // Width of a per-cycle drop count and of the unsaturated sum; the sum
    // width is large enough that max count plus max drops never wraps.
    localparam int CNT_W = $clog2(N_CH + 1);
    localparam int SUM_W = OVF_W + CNT_W;
    localparam logic [OVF_W-1:0] OVF_MAX = '1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    // Registered state
    logic [N_CH-1:0]  s1_q, s2_q, s3_q;
    logic [N_CH-1:0]  pending_q;
    logic [TS_W-1:0]  ts_mem_q [N_CH];
    logic [TS_W-1:0]  ts_cnt_q;
    logic             valid_q;
    logic [CH_W-1:0]  channel_q;
    logic [TS_W-1:0]  ts_out_q;
    logic [OVF_W-1:0] ovf_q;
    logic [CH_W-1:0]  rr_ptr_q;
    state_t           state_q;

    // Next-state values
    logic [N_CH-1:0]  s1_d, s2_d, s3_d;
    logic [N_CH-1:0]  pending_d;
    logic [TS_W-1:0]  ts_mem_d [N_CH];
    logic [TS_W-1:0]  ts_cnt_d;
    logic             valid_d;
    logic [CH_W-1:0]  channel_d;
    logic [TS_W-1:0]  ts_out_d;
    logic [OVF_W-1:0] ovf_d;
    logic [CH_W-1:0]  rr_ptr_d;
    state_t           state_d;

    // Combinational helpers
    logic [N_CH-1:0]  rise;
    logic             handshake;
    logic [N_CH-1:0]  grant_vec;
    logic [N_CH-1:0]  drop_vec;
    logic [CNT_W-1:0] drop_n;
    logic [SUM_W-1:0] ovf_sum;
    logic             found;
    logic [CH_W-1:0]  sel_ch;
    logic [CH_W:0]    scan_idx;

    // Sync chain, edge history and timestamp counter. The history flop s3
    // follows s2 regardless of enable/mask, so a level that was already high
    // while blocked never turns into an edge later.
    always_comb begin
        s1_d     = i_hits;
        s2_d     = s1_q;
        s3_d     = s2_q;
        ts_cnt_d = ts_cnt_q + TS_W'(1);
        rise     = s2_q & ~s3_q & i_ch_mask & {N_CH{i_enable}};
    end

    // Pending flags and stored timestamps. A rise on the channel being
    // handed off this cycle re-arms it with the new timestamp (set wins).
    always_comb begin
        handshake = valid_q & i_ready;
        grant_vec = '0;
        for (int c = 0; c < N_CH; c++) begin
            grant_vec[c] = handshake && (channel_q == CH_W'(c));
        end
        drop_vec  = rise & pending_q & ~grant_vec;
        pending_d = (pending_q & ~grant_vec) | rise;
        ts_mem_d  = ts_mem_q;
        for (int c = 0; c < N_CH; c++) begin
            if (rise[c] && (!pending_q[c] || grant_vec[c])) begin
                ts_mem_d[c] = ts_cnt_q;
            end
        end
    end

    // Saturating drop counter; clear discards same-cycle drops.
    always_comb begin
        drop_n = '0;
        for (int c = 0; c < N_CH; c++) begin
            drop_n = drop_n + CNT_W'(drop_vec[c]);
        end
        ovf_sum = SUM_W'(ovf_q) + SUM_W'(drop_n);
        if (i_clr_ovf) begin
            ovf_d = '0;
        end else if (ovf_sum > SUM_W'(OVF_MAX)) begin
            ovf_d = OVF_MAX;
        end else begin
            ovf_d = ovf_sum[OVF_W-1:0];
        end
    end

    // Round-robin search: first pending channel at or above rr_ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        sel_ch   = '0;
        scan_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            scan_idx = {1'b0, rr_ptr_q} + (CH_W + 1)'(i);
            if (scan_idx >= (CH_W + 1)'(N_CH)) begin
                scan_idx = scan_idx - (CH_W + 1)'(N_CH);
            end
            if (!found && pending_q[scan_idx]) begin
                found  = 1'b1;
                sel_ch = scan_idx[CH_W-1:0];
            end
        end
    end

    // Output sequencer
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        channel_d = channel_q;
        ts_out_d  = ts_out_q;
        rr_ptr_d  = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    channel_d = sel_ch;
                    ts_out_d  = ts_mem_q[sel_ch];
                    valid_d   = 1'b1;
                    state_d   = S_OFFER;
                end
            end
            S_OFFER: begin
                if (i_ready) begin
                    valid_d  = 1'b0;
                    rr_ptr_d = (channel_q == CH_W'(N_CH - 1)) ? '0
                                                              : channel_q + CH_W'(1);
                    state_d  = S_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            pending_q <= '0;
            for (int c = 0; c < N_CH; c++) begin
                ts_mem_q[c] <= '0;
            end
            ts_cnt_q  <= '0;
            valid_q   <= 1'b0;
            channel_q <= '0;
            ts_out_q  <= '0;
            ovf_q     <= '0;
            rr_ptr_q  <= '0;
            state_q   <= S_IDLE;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            pending_q <= pending_d;
            ts_mem_q  <= ts_mem_d;
            ts_cnt_q  <= ts_cnt_d;
            valid_q   <= valid_d;
            channel_q <= channel_d;
            ts_out_q  <= ts_out_d;
            ovf_q     <= ovf_d;
            rr_ptr_q  <= rr_ptr_d;
            state_q   <= state_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_channel   = channel_q;
    assign o_timestamp = ts_out_q;
    assign o_ovf_cnt   = ovf_q;
    assign o_busy      = (|pending_q) | valid_q;

endmodule
